bus_uart_tx: RTL
================

Name: bus_uart_tx

Overview:
- Downstream consumer of the 64-bit, 8-sample packed bus produced by the sampler stage.
- Captures one 64-bit word on a valid/ready handshake and serialises it as 8 consecutive UART 8N1 frames on a single TX pin.
- Sits between the sample packer and the board's UART/USB bridge, so captured samples can be streamed to a host.

Parameters:
- CLKS_PER_BIT, 434, fastclk cycles per UART bit (50 MHz / 115200). Legal range >= 2.
- NUM_BYTES, 8, bytes per captured word; the word width is 8*NUM_BYTES.

Ports:
- fastclk  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_data  input  64  packed sample word; byte k = in_data[8k+7:8k].
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a word; high only in IDLE.
- tx  output  1  UART serial out; idle high.
- busy  output  1  high from the cycle after capture until the last stop bit completes.
- frame_done  output  1  one-cycle pulse when the final stop bit of byte NUM_BYTES-1 completes.

Behaviour:
- All outputs are registered. While reset=0: tx=1, busy=0, in_ready=0, frame_done=0, state=IDLE, and all counters and the shift register are cleared. Assertion takes effect immediately, including mid-frame. In the first clock after release, in_ready rises to 1.
- States:
  - IDLE: tx=1, in_ready=1. When in_valid && in_ready at edge T, latch in_data into a 64-bit holding register, set byte_idx=0, and go to START. At T+1: in_ready=0, busy=1, tx=0.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: tx = current byte bit bit_idx, LSB first, each bit held CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then:
    - if byte_idx < NUM_BYTES-1: byte_idx+1, go to START (back-to-back, no idle gap);
    - else: go to IDLE.
- Byte order: byte 0 (in_data[7:0], oldest sample) is sent first; byte 7 (in_data[63:56]) is sent last.
- Baud counter: width $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. The bit counter is 3 bits; the byte counter is $clog2(NUM_BYTES) bits.
- Word duration: exactly NUM_BYTES*10*CLKS_PER_BIT cycles from the tx falling edge at T+1 to the end of the last stop bit. With defaults this is 80*434 = 34720 cycles.
- Completion: on the edge that ends the last stop bit, assert frame_done=1 for one cycle, and set busy=0 and in_ready=1 in that same cycle.
- Back-to-back words: if in_valid is high in the frame_done cycle, the word is captured on that edge (ready=1). tx falls on the next cycle, giving a 1-cycle idle-high gap between words.
- in_valid while not ready: ignored. No capture and no error. The upstream stage must hold the word until accepted; a dropped word is the upstream's responsibility.
- in_data changing after capture: no effect on the frame in flight, because the holding register is used.
- Glitch-free tx: tx changes only on bit boundaries.
- Reset mid-frame: tx returns high asynchronously. After release the block sits in IDLE and the partial word is discarded.

Test Plan:
- Reset: hold reset=0 for 5 cycles, driving in_valid=1 -> tx=1, busy=0, in_ready=0, frame_done=0 throughout. One cycle after release, in_ready=1.
- Single word (CLKS_PER_BIT=4): in_data=64'h8877665544332211, one-cycle in_valid ->
  - decoded bytes are 11,22,33,44,55,66,77,88 in order;
  - each frame is 40 cycles: start=0, 8 LSB-first bits, stop=1;
  - busy is high for 320 cycles;
  - frame_done pulses once, exactly 320 cycles after tx's first fall.
- Bit timing with default CLKS_PER_BIT=434: in_data=64'h00000000000000A5 -> first frame bits 0,1,0,1,0,0,1,0,1,1, each held exactly 434 cycles; the remaining 7 frames are all-zero data.
- Handshake: assert in_valid with in_data=64'hFFFF... while busy, then change in_data -> not captured, and the frame in flight is unaffected. Then present 64'h0102030405060708 in the frame_done cycle -> captured. tx falls 1 cycle later and bytes 08,07,...,01 follow.
- Reset mid-frame: assert reset=0 during byte 3, bit 4 -> tx=1 in the same cycle (asynchronous), busy=0. After release, a new word 64'h00FF00FF00FF00FF transmits cleanly from byte 0.
- Edge values: 64'h0 and 64'hFFFFFFFFFFFFFFFF -> the start bit is always 0 and the stop bit always 1. The all-ones word has its only low periods at the 8 start bits.

Source files
------------

// File: rtl/bus_uart_tx.sv
// Serialises one captured NUM_BYTES-wide word as back-to-back UART 8N1 frames, byte 0 first.
// Handshake on in_valid/in_ready; every output is a register.
module bus_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int NUM_BYTES    = 8
) (
    input  logic                   fastclk,
    input  logic                   reset,
    input  logic [8*NUM_BYTES-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   tx,
    output logic                   busy,
    output logic                   frame_done
);
    localparam int W   = 8 * NUM_BYTES;
    localparam int BW  = $clog2(CLKS_PER_BIT);
    localparam int BYW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [BW-1:0]  BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [BYW-1:0] BYTE_MAX = BYW'(NUM_BYTES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state_r, state_s;
    logic [BW-1:0]  baud_r, baud_s;
    logic [2:0]     bit_r, bit_s;
    logic [BYW-1:0] byte_r, byte_s;
    logic [W-1:0]   shift_r, shift_s;
    logic [7:0]     cur_byte_s;
    logic           tick_s;
    logic           tx_s, busy_s, ready_s, done_s;

    assign tick_s     = (baud_r == BAUD_MAX);
    assign cur_byte_s = shift_s[7:0];

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_s = state_r;
        baud_s  = baud_r;
        bit_s   = bit_r;
        byte_s  = byte_r;
        shift_s = shift_r;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                baud_s = {BW{1'b0}};
                if (in_valid && in_ready) begin
                    shift_s = in_data;
                    byte_s  = {BYW{1'b0}};
                    bit_s   = 3'd0;
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (tick_s) begin
                    baud_s  = {BW{1'b0}};
                    bit_s   = 3'd0;
                    state_s = DATA;
                end else begin
                    baud_s = baud_r + BW'(1);
                end
            end
            DATA: begin
                if (tick_s) begin
                    baud_s = {BW{1'b0}};
                    if (bit_r == 3'd7) begin
                        state_s = STOP;
                    end else begin
                        bit_s = bit_r + 3'd1;
                    end
                end else begin
                    baud_s = baud_r + BW'(1);
                end
            end
            STOP: begin
                if (tick_s) begin
                    baud_s = {BW{1'b0}};
                    if (byte_r == BYTE_MAX) begin
                        state_s = IDLE;
                        done_s  = 1'b1;
                    end else begin
                        // Drop the finished byte so the next one sits in the low lane.
                        byte_s  = byte_r + BYW'(1);
                        shift_s = {8'h00, shift_r[W-1:8]};
                        state_s = START;
                    end
                end else begin
                    baud_s = baud_r + BW'(1);
                end
            end
            default: begin
                state_s = IDLE;
                baud_s  = {BW{1'b0}};
            end
        endcase

        case (state_s)
            START:   tx_s = 1'b0;
            DATA:    tx_s = cur_byte_s[bit_s];
            default: tx_s = 1'b1;
        endcase
        busy_s  = (state_s != IDLE);
        ready_s = (state_s == IDLE);
    end

    // State, counters, holding register and outputs.
    always_ff @(posedge fastclk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            baud_r     <= {BW{1'b0}};
            bit_r      <= 3'd0;
            byte_r     <= {BYW{1'b0}};
            shift_r    <= {W{1'b0}};
            tx         <= 1'b1;
            busy       <= 1'b0;
            in_ready   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_r    <= state_s;
            baud_r     <= baud_s;
            bit_r      <= bit_s;
            byte_r     <= byte_s;
            shift_r    <= shift_s;
            tx         <= tx_s;
            busy       <= busy_s;
            in_ready   <= ready_s;
            frame_done <= done_s;
        end
    end
endmodule
